// File: rtl/stage_3_ex_pkg.sv
// Shared definitions for the EX stage: bus layouts, ALU op bit indices and FSM states.
package stage_3_ex_pkg;

    localparam int unsigned BUS_IN_W  = 117;
    localparam int unsigned BUS_OUT_W = 71;

    // stage_2_to_3 = {rf_we, dest, res_from_mem, src1, src2, alu_op, mem_we, mem_en, pc}
    localparam int unsigned IN_PC_LSB   = 0;
    localparam int unsigned IN_MEM_EN   = 32;
    localparam int unsigned IN_MEM_WE   = 33;
    localparam int unsigned IN_OP_LSB   = 34;
    localparam int unsigned IN_SRC2_LSB = 46;
    localparam int unsigned IN_SRC1_LSB = 78;
    localparam int unsigned IN_RFM      = 110;
    localparam int unsigned IN_DEST_LSB = 111;
    localparam int unsigned IN_RF_WE    = 116;

    // stage_3_to_4 = {rf_we, dest, res_from_mem, alu_result, pc}
    localparam int unsigned OUT_PC_LSB   = 0;
    localparam int unsigned OUT_RES_LSB  = 32;
    localparam int unsigned OUT_RFM      = 64;
    localparam int unsigned OUT_DEST_LSB = 65;
    localparam int unsigned OUT_RF_WE    = 70;

    localparam int unsigned OP_ADD   = 0;
    localparam int unsigned OP_SUB   = 1;
    localparam int unsigned OP_SLT   = 2;
    localparam int unsigned OP_SLTU  = 3;
    localparam int unsigned OP_AND   = 4;
    localparam int unsigned OP_NOR   = 5;
    localparam int unsigned OP_OR    = 6;
    localparam int unsigned OP_XOR   = 7;
    localparam int unsigned OP_SLL   = 8;
    localparam int unsigned OP_SRL   = 9;
    localparam int unsigned OP_SRA   = 10;
    localparam int unsigned OP_LUI   = 11;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_ACC  = 2'd2
    } state_t;

endpackage

// File: rtl/stage_3_ex_alu.sv
// 12-op one-hot ALU; an all-zero op yields zero.
module stage_3_ex_alu
    import stage_3_ex_pkg::*;
(
    input  logic [31:0] src1,
    input  logic [31:0] src2,
    input  logic [11:0] op,
    output logic [31:0] result
);
    logic [4:0] sh;

    assign sh = src2[4:0];

    always_comb begin
        result = '0;
        if (op[OP_ADD])  result = result | (src1 + src2);
        if (op[OP_SUB])  result = result | (src1 - src2);
        if (op[OP_SLT])  result = result | {31'd0, $signed(src1) < $signed(src2)};
        if (op[OP_SLTU]) result = result | {31'd0, src1 < src2};
        if (op[OP_AND])  result = result | (src1 & src2);
        if (op[OP_NOR])  result = result | ~(src1 | src2);
        if (op[OP_OR])   result = result | (src1 | src2);
        if (op[OP_XOR])  result = result | (src1 ^ src2);
        if (op[OP_SLL])  result = result | (src1 << sh);
        if (op[OP_SRL])  result = result | (src1 >> sh);
        if (op[OP_SRA])  result = result | 32'($signed(src1) >>> sh);
        if (op[OP_LUI])  result = result | src2;
    end

endmodule

// File: rtl/stage_3_ex.sv
// EX pipeline stage: latches the ID bus, runs the ALU and issues one data-SRAM request per memory op.
module stage_3_ex
    import stage_3_ex_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 valid_2,
    output logic                 allow_3,
    output logic                 valid_3,
    input  logic                 allow_4,
    input  logic [BUS_IN_W-1:0]  stage_2_to_3,
    input  logic [31:0]          memory_write_data,
    output logic [BUS_OUT_W-1:0] stage_3_to_4,
    output logic [4:0]           rf_waddr_3_fwd,
    output logic                 data_sram_req,
    output logic                 data_sram_wr,
    output logic [3:0]           data_sram_wstrb,
    output logic [31:0]          data_sram_addr,
    output logic [31:0]          data_sram_wdata,
    input  logic                 data_sram_addr_ok
);
    logic [BUS_IN_W-1:0] bus;
    logic [31:0]         store_data;
    state_t              state;

    logic        rf_we;
    logic [4:0]  dest;
    logic        res_from_mem;
    logic [31:0] src1;
    logic [31:0] src2;
    logic [11:0] alu_op;
    logic        mem_we;
    logic        mem_en;
    logic [31:0] pc;
    logic [31:0] alu_result;
    logic        readygo_3;

    assign rf_we        = bus[IN_RF_WE];
    assign dest         = bus[IN_DEST_LSB +: 5];
    assign res_from_mem = bus[IN_RFM];
    assign src1         = bus[IN_SRC1_LSB +: 32];
    assign src2         = bus[IN_SRC2_LSB +: 32];
    assign alu_op       = bus[IN_OP_LSB +: 12];
    assign mem_we       = bus[IN_MEM_WE];
    assign mem_en       = bus[IN_MEM_EN];
    assign pc           = bus[IN_PC_LSB +: 32];

    stage_3_ex_alu u_alu (
        .src1   (src1),
        .src2   (src2),
        .op     (alu_op),
        .result (alu_result)
    );

    assign readygo_3 = ~mem_en
                     | ((state == S_REQ) & data_sram_addr_ok)
                     | (state == S_ACC);
    assign allow_3   = ~valid_3 | (readygo_3 & allow_4);

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_3    <= 1'b0;
            bus        <= '0;
            store_data <= '0;
            state      <= S_IDLE;
        end else begin
            if (allow_3) begin
                valid_3 <= valid_2;
                if (valid_2) begin
                    bus        <= stage_2_to_3;
                    store_data <= memory_write_data;
                end
            end
            // Latch decision dominates: a leaving instruction hands the FSM to the new entry.
            if (allow_3) begin
                state <= (valid_2 & stage_2_to_3[IN_MEM_EN]) ? S_REQ : S_IDLE;
            end else if ((state == S_REQ) & data_sram_addr_ok) begin
                state <= S_ACC;
            end
        end
    end

    assign stage_3_to_4    = {rf_we, dest, res_from_mem, alu_result, pc};
    assign rf_waddr_3_fwd  = (valid_3 & rf_we) ? dest : 5'd0;
    assign data_sram_req   = valid_3 & (state == S_REQ);
    assign data_sram_wr    = mem_we;
    assign data_sram_wstrb = mem_we ? 4'hf : 4'h0;
    assign data_sram_addr  = alu_result;
    assign data_sram_wdata = store_data;

endmodule

// File: tb/tb_stage_3_ex.sv
// Directed and randomized checks of the EX stage against a behavioural reference.
module tb_stage_3_ex;
    logic         clk = 1'b0;
    logic         reset;
    logic         valid_2;
    logic         allow_3;
    logic         valid_3;
    logic         allow_4;
    logic [116:0] stage_2_to_3;
    logic [31:0]  memory_write_data;
    logic [70:0]  stage_3_to_4;
    logic [4:0]   rf_waddr_3_fwd;
    logic         data_sram_req;
    logic         data_sram_wr;
    logic [3:0]   data_sram_wstrb;
    logic [31:0]  data_sram_addr;
    logic [31:0]  data_sram_wdata;
    logic         data_sram_addr_ok;

    int checks = 0;
    int errors = 0;

    stage_3_ex dut (
        .clk               (clk),
        .reset             (reset),
        .valid_2           (valid_2),
        .allow_3           (allow_3),
        .valid_3           (valid_3),
        .allow_4           (allow_4),
        .stage_2_to_3      (stage_2_to_3),
        .memory_write_data (memory_write_data),
        .stage_3_to_4      (stage_3_to_4),
        .rf_waddr_3_fwd    (rf_waddr_3_fwd),
        .data_sram_req     (data_sram_req),
        .data_sram_wr      (data_sram_wr),
        .data_sram_wstrb   (data_sram_wstrb),
        .data_sram_addr    (data_sram_addr),
        .data_sram_wdata   (data_sram_wdata),
        .data_sram_addr_ok (data_sram_addr_ok)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference ALU: op index 0..11 selects an operation, anything else means no op bit set.
    function automatic logic [31:0] alu_ref(input int idx, input logic [31:0] a, input logic [31:0] b);
        int sa = a;
        int sb = b;
        int unsigned sh = b % 32;
        case (idx)
            0:  return a + b;
            1:  return a - b;
            2:  return (sa < sb) ? 32'd1 : 32'd0;
            3:  return (a < b) ? 32'd1 : 32'd0;
            4:  return a & b;
            5:  return ~(a | b);
            6:  return a | b;
            7:  return a ^ b;
            8:  return a << sh;
            9:  return a >> sh;
            10: return a[31] ? ~((~a) >> sh) : (a >> sh);
            11: return b;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [11:0] op_of(input int idx);
        logic [11:0] o = 12'd0;
        if (idx >= 0 && idx < 12) o[idx] = 1'b1;
        return o;
    endfunction

    function automatic logic [116:0] mk(input logic we, input logic [4:0] d, input logic rfm,
                                        input logic [31:0] a, input logic [31:0] b, input logic [11:0] op,
                                        input logic mwe, input logic men, input logic [31:0] p);
        return {we, d, rfm, a, b, op, mwe, men, p};
    endfunction

    // Issues one non-memory op, checks the 1-cycle EX result, then lets it drain.
    task automatic run_alu(input string tag, input int idx, input logic [31:0] a, input logic [31:0] b,
                           input logic we, input logic [4:0] d);
        logic [31:0] p = $urandom;
        logic [31:0] res = alu_ref(idx, a, b);
        stage_2_to_3 = mk(we, d, 1'b0, a, b, op_of(idx), 1'b0, 1'b0, p);
        valid_2 = 1'b1;
        allow_4 = 1'b1;
        data_sram_addr_ok = 1'b0;
        tick();
        valid_2 = 1'b0;
        #1;
        chk({tag, "_valid"}, 128'(valid_3), 128'(1'b1));
        chk({tag, "_bus"}, 128'(stage_3_to_4), 128'({we, d, 1'b0, res, p}));
        chk({tag, "_req"}, 128'(data_sram_req), 128'(1'b0));
        chk({tag, "_fwd"}, 128'(rf_waddr_3_fwd), 128'(we ? d : 5'd0));
        chk({tag, "_allow"}, 128'(allow_3), 128'(1'b1));
        tick();
        chk({tag, "_drain"}, 128'(valid_3), 128'(1'b0));
    endtask

    initial begin
        int req_cycles;
        reset = 1'b1;
        valid_2 = 1'b0;
        allow_4 = 1'b1;
        stage_2_to_3 = '0;
        memory_write_data = '0;
        data_sram_addr_ok = 1'b0;
        tick();
        tick();
        chk("rst_valid", 128'(valid_3), 128'(1'b0));
        chk("rst_req", 128'(data_sram_req), 128'(1'b0));
        chk("rst_fwd", 128'(rf_waddr_3_fwd), 128'(5'd0));
        chk("rst_bus", 128'(stage_3_to_4), 128'(71'd0));
        chk("rst_allow", 128'(allow_3), 128'(1'b1));
        reset = 1'b0;

        run_alu("add", 0, 32'd7, 32'd5, 1'b1, 5'd5);
        run_alu("sra", 10, 32'h8000_0000, 32'd4, 1'b1, 5'd1);
        run_alu("srl", 9, 32'h8000_0000, 32'd4, 1'b1, 5'd2);
        run_alu("slt", 2, 32'hFFFF_FFFF, 32'd1, 1'b1, 5'd3);
        run_alu("sltu", 3, 32'hFFFF_FFFF, 32'd1, 1'b0, 5'd4);
        run_alu("noop", 12, 32'h1234_5678, 32'h9ABC_DEF0, 1'b1, 5'd6);
        for (int unsigned i = 0; i < 24; i++)
            run_alu("rnd", int'($urandom_range(0, 12)), $urandom, $urandom, 1'($urandom), 5'($urandom));

        // Store held by addr_ok=0 for three cycles; a following add waits in ID.
        stage_2_to_3 = mk(1'b0, 5'd0, 1'b0, 32'h1000, 32'd8, op_of(0), 1'b1, 1'b1, 32'h40);
        memory_write_data = 32'hDEAD_BEEF;
        valid_2 = 1'b1;
        allow_4 = 1'b1;
        tick();
        stage_2_to_3 = mk(1'b1, 5'd7, 1'b0, 32'd20, 32'd22, op_of(0), 1'b0, 1'b0, 32'h44);
        memory_write_data = 32'h0;
        req_cycles = 0;
        for (int unsigned c = 0; c < 4; c++) begin
            data_sram_addr_ok = (c == 3);
            #1;
            if (data_sram_req === 1'b1) req_cycles++;
            chk("st_addr", 128'(data_sram_addr), 128'(32'h1008));
            chk("st_wdata", 128'(data_sram_wdata), 128'(32'hDEAD_BEEF));
            chk("st_wstrb", 128'(data_sram_wstrb), 128'(4'hf));
            chk("st_wr", 128'(data_sram_wr), 128'(1'b1));
            chk("st_allow", 128'(allow_3), 128'(c == 3));
            tick();
        end
        chk("st_req_cycles", 128'(req_cycles), 128'(4));
        data_sram_addr_ok = 1'b0;
        valid_2 = 1'b0;
        #1;
        chk("st_next_bus", 128'(stage_3_to_4), 128'({1'b1, 5'd7, 1'b0, 32'd42, 32'h44}));
        chk("st_next_req", 128'(data_sram_req), 128'(1'b0));
        tick();

        // Load accepted at once, then back-pressured for two cycles.
        stage_2_to_3 = mk(1'b1, 5'd3, 1'b1, 32'h2000, 32'h10, op_of(0), 1'b0, 1'b1, 32'h48);
        valid_2 = 1'b1;
        allow_4 = 1'b0;
        data_sram_addr_ok = 1'b1;
        tick();
        valid_2 = 1'b0;
        #1;
        req_cycles = 0;
        chk("ld_addr", 128'(data_sram_addr), 128'(32'h2010));
        chk("ld_wstrb", 128'(data_sram_wstrb), 128'(4'h0));
        chk("ld_wr", 128'(data_sram_wr), 128'(1'b0));
        for (int unsigned c = 0; c < 3; c++) begin
            if (c == 2) allow_4 = 1'b1;
            #1;
            if (data_sram_req === 1'b1) req_cycles++;
            chk("ld_valid", 128'(valid_3), 128'(1'b1));
            chk("ld_allow", 128'(allow_3), 128'(c == 2));
            tick();
        end
        chk("ld_req_cycles", 128'(req_cycles), 128'(1));
        chk("ld_left", 128'(valid_3), 128'(1'b0));
        data_sram_addr_ok = 1'b0;

        // Stale destination must not be forwarded once the stage is empty.
        run_alu("stale", 0, 32'd1, 32'd2, 1'b1, 5'd9);
        chk("stale_fwd", 128'(rf_waddr_3_fwd), 128'(5'd0));

        // Reset while a store request is outstanding.
        stage_2_to_3 = mk(1'b0, 5'd0, 1'b0, 32'h3000, 32'h4, op_of(0), 1'b1, 1'b1, 32'h50);
        memory_write_data = 32'h1111_2222;
        valid_2 = 1'b1;
        tick();
        valid_2 = 1'b0;
        #1;
        chk("rstreq_req", 128'(data_sram_req), 128'(1'b1));
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        chk("rstreq_req_drop", 128'(data_sram_req), 128'(1'b0));
        chk("rstreq_valid", 128'(valid_3), 128'(1'b0));
        chk("rstreq_allow", 128'(allow_3), 128'(1'b1));
        run_alu("post_rst_add", 0, 32'd100, 32'd23, 1'b1, 5'd12);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end
endmodule
